// File: rtl/hamm_scrub_pkg.sv
// Shared definitions for the Hamming parity table scrubber: FSM encoding,
// parity function (also used by the upstream writer) and syndrome decode codes.
package hamm_scrub_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] SYN_D3 = 3'b111;
    localparam logic [2:0] SYN_D2 = 3'b110;
    localparam logic [2:0] SYN_D1 = 3'b101;
    localparam logic [2:0] SYN_D0 = 3'b011;
    localparam logic [2:0] SYN_P2 = 3'b100;
    localparam logic [2:0] SYN_P1 = 3'b010;
    localparam logic [2:0] SYN_P0 = 3'b001;

    // Position code of the flipped bit; POS_NONE means the entry is clean.
    localparam logic [2:0] POS_NONE = 3'd0;
    localparam logic [2:0] POS_P0   = 3'd1;
    localparam logic [2:0] POS_P1   = 3'd2;
    localparam logic [2:0] POS_P2   = 3'd3;
    localparam logic [2:0] POS_D0   = 3'd4;
    localparam logic [2:0] POS_D1   = 3'd5;
    localparam logic [2:0] POS_D2   = 3'd6;
    localparam logic [2:0] POS_D3   = 3'd7;

    function automatic logic [2:0] hamm_parity(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[1],
                d[3] ^ d[2] ^ d[0],
                d[3] ^ d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/hamm_scrub_if.sv
// RAM port bundle between the scrubber (master) and the 32x3 parity RAM (slave).
interface hamm_scrub_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_q;
    logic              ram_wren;
    logic [2:0]        ram_data;

    modport master (output ram_addr, output ram_wren, output ram_data, input ram_q);
    modport slave  (input ram_addr, input ram_wren, input ram_data, output ram_q);
endinterface

// File: rtl/hamm_syndrome.sv
// Combinational syndrome computation and flipped-bit classification for one
// parity entry, given the address nibble and the stored parity word.
module hamm_syndrome
    import hamm_scrub_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic [2:0] stored,
    output logic [2:0] syndrome,
    output logic       err,
    output logic [2:0] pos
);

    always_comb begin
        syndrome = stored ^ hamm_parity(nibble);
        err      = |syndrome;
        case (syndrome)
            SYN_D3:  pos = POS_D3;
            SYN_D2:  pos = POS_D2;
            SYN_D1:  pos = POS_D1;
            SYN_D0:  pos = POS_D0;
            SYN_P2:  pos = POS_P2;
            SYN_P1:  pos = POS_P1;
            SYN_P0:  pos = POS_P0;
            default: pos = POS_NONE;
        endcase
    end

endmodule

// File: rtl/hamm_scrub.sv
// Scans the parity RAM, reports and counts Hamming parity mismatches.
// Define HAMM_SCRUB_WRITEBACK_EN to rewrite bad entries with the expected parity.
module hamm_scrub
    import hamm_scrub_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    hamm_scrub_if.master      ram,
    output logic              busy,
    output logic              done,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic [2:0]        syndrome,
    output logic [ADDR_W:0]   err_count
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [2:0]        syndrome_q, syndrome_d;

    logic [2:0] syn;
    logic       syn_err;
    logic [2:0] flip_pos;
    logic       hit;
    logic       last;

    hamm_syndrome u_syn (
        .nibble   (index_q[3:0]),
        .stored   (ram.ram_q),
        .syndrome (syn),
        .err      (syn_err),
        .pos      (flip_pos)
    );

    assign hit  = (state_q == S_CHECK) && syn_err && (flip_pos != POS_NONE);
    assign last = (index_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        syndrome_d  = syndrome_q;
        case (state_q)
            S_IDLE: begin
                index_d = '0;
                if (start) begin
                    state_d     = S_ADDR;
                    err_count_d = '0;
                    err_addr_d  = '0;
                    syndrome_d  = '0;
                end
            end
            S_ADDR: state_d = S_CHECK;
            S_CHECK: begin
                if (hit) begin
                    err_addr_d  = index_q;
                    syndrome_d  = syn;
                    err_count_d = err_count_q + 1'b1;
                end
`ifdef HAMM_SCRUB_WRITEBACK_EN
                if (hit) begin
                    state_d = S_FIX;
                end else if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADDR;
                    index_d = index_q + 1'b1;
                end
`else
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADDR;
                    index_d = index_q + 1'b1;
                end
`endif
            end
`ifdef HAMM_SCRUB_WRITEBACK_EN
            S_FIX: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADDR;
                    index_d = index_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                index_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            syndrome_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            syndrome_q  <= syndrome_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err_valid = hit;
    assign err_addr  = err_addr_q;
    assign syndrome  = syndrome_q;
    assign err_count = err_count_q;

    assign ram.ram_addr = index_q;
`ifdef HAMM_SCRUB_WRITEBACK_EN
    assign ram.ram_wren = (state_q == S_FIX);
    assign ram.ram_data = (state_q == S_FIX) ? hamm_parity(index_q[3:0]) : '0;
`else
    assign ram.ram_wren = 1'b0;
    assign ram.ram_data = '0;
`endif

endmodule
